fetch_unit: RTL

Instruction fetch stage, directly upstream of decode. Owns the architectural fetch PC and issues word requests to instruction memory over a request/grant + in-order response interface. Buffers returned instructions with their PCs in a small queue and presents them to decode through a valid/ready handshake. Handles control-flow redirects by flushing the queue and discarding in-flight responses.

---
 rtl/fetch_unit.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage that owns the fetch PC and feeds decode.
// Latency: 1 cycle from rvalid to valid_o, so at least 2 cycles from grant to valid_o.
//          Sustains 1 insn/cycle with a 1-cycle memory.
// Backpressure: ready_i low holds the head entry. Requests stop once in-flight plus
//               buffered entries reach DEPTH. A redirect flushes and restarts fetch.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   imem_req_o / imem_addr_o        fetch request and word address (held until granted)
//   imem_gnt_i                      memory accepted the request this cycle
//   imem_rvalid_i / imem_rdata_i    in-order response, at least one cycle after grant
//   valid_o / ready_i               handshake towards decode
//   pc_o / insn_o                   head instruction and its PC
//                                   (fetch PC and INSN_NOP while idle)
//   redirect_i / redirect_pc_i      flush and restart at a new PC
//   halt_i                          stop issuing new requests until the next redirect
//   fault_o                         only with FETCH_MISALIGN_CHECK_EN: sticky misaligned-redirect flag
//
// Build option: define FETCH_MISALIGN_CHECK_EN to trap misaligned redirect targets.
// Without it, the low two bits of redirect_pc_i are cleared.
module fetch_unit #(
  parameter int unsigned       DWIDTH         = 32,
  parameter int unsigned       AWIDTH         = 32,
  parameter logic [AWIDTH-1:0] IMEM_BASE_ADDR = AWIDTH'(32'h0000_1000),
  parameter logic [AWIDTH-1:0] RESET_PC       = IMEM_BASE_ADDR,
  parameter int unsigned       DEPTH          = 4,
  parameter logic [DWIDTH-1:0] INSN_NOP       = DWIDTH'(32'h0000_0013)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_o,
  output logic [AWIDTH-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [DWIDTH-1:0] imem_rdata_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] insn_o,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  input  logic              halt_i
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic              fault_o
`endif
);

  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = PW + 1;
  // The drop counter holds responses still owed for flushed requests.
  // Back-to-back redirects can pile up several queues' worth of them,
  // so this counter is sized for up to 8*DEPTH.
  localparam int unsigned DRW = PW + 3;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Queue storage. Entries are allocated at grant time, so the PC is known
  // before the data returns. dvld marks entries whose data has arrived.
  logic [AWIDTH-1:0] pc_mem   [DEPTH];
  logic [DWIDTH-1:0] insn_mem [DEPTH];
  logic [DEPTH-1:0]  dvld_q;

  // head: oldest entry. tail: next entry to allocate.
  // fill: oldest allocated entry still waiting for data.
  logic [PW-1:0]     head_q, tail_q, fill_q;
  logic [CW-1:0]     outst_q;   // granted, data not yet returned
  logic [CW-1:0]     count_q;   // data returned, not yet popped
  logic [DRW-1:0]    drop_q, drop_d;
  logic [AWIDTH-1:0] fetch_pc_q;

  logic              fault_q;
  logic              misalign;
  logic [AWIDTH-1:0] redirect_pc;
  logic [CW:0]       inflight;
  logic              credit_ok;
  logic              req;
  logic              alloc;
  logic              resp_live;
  logic              resp_drop;
  logic              resp_any;
  logic              head_vld;
  logic              pop;

  // ---------------------------------------------------------------------
  // Redirect target handling
  // ---------------------------------------------------------------------
`ifdef FETCH_MISALIGN_CHECK_EN
  assign redirect_pc = redirect_pc_i;
  assign misalign    = |redirect_pc_i[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else if (redirect_i && misalign) begin
      fault_q <= 1'b1;
    end
  end

  assign fault_o = fault_q;
`else
  assign redirect_pc = redirect_pc_i & ~AWIDTH'(3);
  assign misalign    = 1'b0;
  assign fault_q     = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Request and event decode
  // ---------------------------------------------------------------------
  // Credit uses registered counts only: a pop this cycle frees its slot next cycle.
  assign inflight  = {1'b0, outst_q} + {1'b0, count_q};
  assign credit_ok = inflight < (CW + 1)'(DEPTH);

  assign req = (state_q == S_RUN) && !redirect_i && !halt_i && credit_ok && !fault_q;

  assign alloc     = req && imem_gnt_i;
  assign resp_drop = imem_rvalid_i && (drop_q != '0);
  // A response with nothing owed is stray and is ignored.
  assign resp_live = imem_rvalid_i && (drop_q == '0) && (outst_q != '0);
  assign resp_any  = resp_live || resp_drop;

  assign head_vld = dvld_q[head_q];
  assign pop      = head_vld && ready_i;

  // On a redirect, every request still outstanding turns into a response to
  // drop. A response arriving in the redirect cycle itself is discarded now,
  // so it does not need to be counted.
  always_comb begin
    drop_d = drop_q;
    if (redirect_i) begin
      drop_d = drop_q + DRW'(outst_q) - DRW'(resp_any);
    end else if (resp_drop) begin
      drop_d = drop_q - DRW'(1);
    end
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   if (halt_i) state_d = S_HALT;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_BOOT;
    endcase
    // A redirect wins over halt and also leaves HALT.
    // The exception is a trapped misaligned target, which parks in HALT.
    if (redirect_i) begin
      state_d = misalign ? S_HALT : S_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // Queue control, counters and fetch PC
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      outst_q    <= '0;
      count_q    <= '0;
      drop_q     <= '0;
      dvld_q     <= '0;
      fetch_pc_q <= RESET_PC;
    end else if (redirect_i) begin
      // Any pop in this cycle has already been seen by decode.
      // Everything else is discarded.
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      outst_q    <= '0;
      count_q    <= '0;
      drop_q     <= drop_d;
      dvld_q     <= '0;
      fetch_pc_q <= redirect_pc;
    end else begin
      drop_q  <= drop_d;
      outst_q <= outst_q + CW'(alloc) - CW'(resp_live);
      count_q <= count_q + CW'(resp_live) - CW'(pop);
      if (alloc) begin
        tail_q     <= tail_q + PW'(1);
        fetch_pc_q <= fetch_pc_q + AWIDTH'(4);
      end
      // The fill slot lacks data and the head slot has it, so these two
      // updates never target the same bit.
      if (resp_live) begin
        dvld_q[fill_q] <= 1'b1;
        fill_q         <= fill_q + PW'(1);
      end
      if (pop) begin
        dvld_q[head_q] <= 1'b0;
        head_q         <= head_q + PW'(1);
      end
    end
  end

  // Datapath storage needs no reset: dvld_q qualifies every read.
  always_ff @(posedge clk) begin
    if (alloc) begin
      pc_mem[tail_q] <= fetch_pc_q;
    end
    if (resp_live && !redirect_i) begin
      insn_mem[fill_q] <= imem_rdata_i;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign imem_req_o  = req;
  assign imem_addr_o = fetch_pc_q;
  assign valid_o     = head_vld;
  assign pc_o        = head_vld ? pc_mem[head_q]   : fetch_pc_q;
  assign insn_o      = head_vld ? insn_mem[head_q] : INSN_NOP;

endmodule
